// File: rtl/uart_rx_frame_parser.sv
// Purpose : pulls bytes from the UART RX FIFO, hunts HEAD0/HEAD1/LEN/payload/CHK frames and releases verified payloads.
// Latency : CHK byte valid in cycle t -> frame_ok_o and first payload byte in t+1; at most one FIFO read every 2 cycles.
// Backpr. : payload_valid_o/payload_ready_i stream; the FIFO is not read while a payload drains.
//
// Ports:
//   sys_clk_i, rst_n_i                  clock (also FIFO read clock), async active-low reset
//   fifo_rx_rd_en_o                     registered read strobe, one byte per pulse
//   fifo_rx_dout_valid_i/_dout_i        read data, valid exactly one cycle after the strobe
//   fifo_rx_empty_i                     FIFO empty flag
//   payload_valid_o/_data_o/_last_o     payload byte stream; payload_ready_i accepts a byte
//   frame_ok_o, frame_len_o             verified-frame pulse and its LEN (held until the next one)
//   err_chk_cnt_o/_len_/_timeout_       saturating error counters
module uart_rx_frame_parser #(
    parameter logic [7:0]  HEAD0          = 8'h55,
    parameter logic [7:0]  HEAD1          = 8'hAA,
    parameter int          MAX_LEN        = 32,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic       sys_clk_i,
    input  logic       rst_n_i,
    output logic       fifo_rx_rd_en_o,
    input  logic       fifo_rx_dout_valid_i,
    input  logic [7:0] fifo_rx_dout_i,
    input  logic       fifo_rx_empty_i,
    output logic       payload_valid_o,
    output logic [7:0] payload_data_o,
    output logic       payload_last_o,
    input  logic       payload_ready_i,
    output logic       frame_ok_o,
    output logic [7:0] frame_len_o,
    output logic [7:0] err_chk_cnt_o,
    output logic [7:0] err_len_cnt_o,
    output logic [7:0] err_timeout_cnt_o
);
    localparam int         IDX_W     = $clog2(MAX_LEN + 1);
    localparam int         ADDR_W    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        S_HUNT0, S_HUNT1, S_LEN, S_PAYLOAD, S_CHK, S_DRAIN
    } state_t;

    state_t           state_r, state_nxt;
    logic [7:0]       len_r;
    logic [7:0]       sum_r;
    logic [IDX_W-1:0] idx_r;
    logic [IDX_W-1:0] drain_idx_r;
    logic [IDX_W-1:0] drain_nxt;
    logic [15:0]      idle_r;
    logic             rd_pend_r;
    logic [7:0]       pay_mem_r [0:MAX_LEN-1];

    logic in_frame, rd_busy, timeout, byte_vld;
    logic len_bad, chk_ok, pay_done;
    logic drain_hs, drain_end, rd_issue;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_comb begin
        in_frame  = (state_r == S_HUNT1) || (state_r == S_LEN) ||
                    (state_r == S_PAYLOAD) || (state_r == S_CHK);
        // Outstanding read spans the strobe cycle and the data cycle.
        rd_busy   = fifo_rx_rd_en_o || rd_pend_r;
        timeout   = in_frame && !rd_busy && (idle_r >= TIMEOUT_CYCLES);
        byte_vld  = fifo_rx_dout_valid_i && !timeout;
        len_bad   = (fifo_rx_dout_i == 8'd0) || (fifo_rx_dout_i > MAX_LEN_B);
        chk_ok    = (fifo_rx_dout_i == sum_r);
        pay_done  = ((8'(idx_r) + 8'd1) == len_r);
        drain_hs  = (state_r == S_DRAIN) && payload_valid_o && payload_ready_i;
        drain_end = drain_hs && ((8'(drain_idx_r) + 8'd1) == len_r);
        drain_nxt = drain_idx_r + 1'b1;

        state_nxt = state_r;
        if (timeout) begin
            state_nxt = S_HUNT0;
        end else begin
            if (byte_vld) begin
                case (state_r)
                    S_HUNT0:   if (fifo_rx_dout_i == HEAD0) state_nxt = S_HUNT1;
                    S_HUNT1:   if (fifo_rx_dout_i == HEAD1) state_nxt = S_LEN;
                               else if (fifo_rx_dout_i != HEAD0) state_nxt = S_HUNT0;
                    S_LEN:     state_nxt = len_bad ? S_HUNT0 : S_PAYLOAD;
                    S_PAYLOAD: if (pay_done) state_nxt = S_CHK;
                    S_CHK:     state_nxt = chk_ok ? S_DRAIN : S_HUNT0;
                    default:   state_nxt = state_r;
                endcase
            end
            if (drain_end) state_nxt = S_HUNT0;
        end

        // Decided on the next state so no read is launched into DRAIN, and a
        // read may start in the very cycle the parser returns to HUNT0.
        rd_issue = (state_nxt != S_DRAIN) && !fifo_rx_empty_i && !fifo_rx_rd_en_o &&
                   (!rd_pend_r || fifo_rx_dout_valid_i);
    end

    // Payload buffer: plain storage, no reset needed.
    always_ff @(posedge sys_clk_i) begin
        if (byte_vld && state_r == S_PAYLOAD)
            pay_mem_r[idx_r[ADDR_W-1:0]] <= fifo_rx_dout_i;
    end

    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r           <= S_HUNT0;
            len_r             <= 8'd0;
            sum_r             <= 8'd0;
            idx_r             <= '0;
            drain_idx_r       <= '0;
            idle_r            <= 16'd0;
            rd_pend_r         <= 1'b0;
            fifo_rx_rd_en_o   <= 1'b0;
            payload_valid_o   <= 1'b0;
            payload_data_o    <= 8'd0;
            payload_last_o    <= 1'b0;
            frame_ok_o        <= 1'b0;
            frame_len_o       <= 8'd0;
            err_chk_cnt_o     <= 8'd0;
            err_len_cnt_o     <= 8'd0;
            err_timeout_cnt_o <= 8'd0;
        end else begin
            state_r         <= state_nxt;
            frame_ok_o      <= 1'b0;
            fifo_rx_rd_en_o <= rd_issue;

            if (fifo_rx_rd_en_o)           rd_pend_r <= 1'b1;
            else if (fifo_rx_dout_valid_i) rd_pend_r <= 1'b0;

            // Idle counter restarts on every byte and every state change.
            if (!in_frame || fifo_rx_dout_valid_i || state_nxt != state_r)
                idle_r <= 16'd0;
            else if (idle_r != 16'hFFFF)
                idle_r <= idle_r + 16'd1;

            if (timeout)
                err_timeout_cnt_o <= sat_inc(err_timeout_cnt_o);

            if (byte_vld) begin
                case (state_r)
                    S_LEN: begin
                        if (len_bad) begin
                            err_len_cnt_o <= sat_inc(err_len_cnt_o);
                        end else begin
                            len_r <= fifo_rx_dout_i;
                            sum_r <= fifo_rx_dout_i;
                            idx_r <= '0;
                        end
                    end
                    S_PAYLOAD: begin
                        sum_r <= sum_r + fifo_rx_dout_i;
                        idx_r <= idx_r + 1'b1;
                    end
                    S_CHK: begin
                        if (chk_ok) begin
                            frame_ok_o      <= 1'b1;
                            frame_len_o     <= len_r;
                            payload_valid_o <= 1'b1;
                            payload_data_o  <= pay_mem_r[0];
                            payload_last_o  <= (len_r == 8'd1);
                            drain_idx_r     <= '0;
                        end else begin
                            err_chk_cnt_o <= sat_inc(err_chk_cnt_o);
                        end
                    end
                    default: ;
                endcase
            end

            if (drain_hs) begin
                if (drain_end) begin
                    payload_valid_o <= 1'b0;
                    payload_last_o  <= 1'b0;
                end else begin
                    drain_idx_r    <= drain_nxt;
                    payload_data_o <= pay_mem_r[drain_nxt[ADDR_W-1:0]];
                    payload_last_o <= ((8'(drain_nxt) + 8'd1) == len_r);
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Bench for uart_rx_frame_parser: drives a byte-queue FIFO model and compares the
// payload stream and error counters against a frame-scanning reference model.
module tb_uart_rx_frame_parser;
    localparam int MAX_LEN = 32;
    typedef logic [7:0] bq_t [$];

    logic       sys_clk_i = 1'b0;
    logic       rst_n_i;
    logic       fifo_rx_rd_en_o;
    logic       fifo_rx_dout_valid_i;
    logic [7:0] fifo_rx_dout_i;
    logic       fifo_rx_empty_i;
    logic       payload_valid_o;
    logic [7:0] payload_data_o;
    logic       payload_last_o;
    logic       payload_ready_i;
    logic       frame_ok_o;
    logic [7:0] frame_len_o;
    logic [7:0] err_chk_cnt_o;
    logic [7:0] err_len_cnt_o;
    logic [7:0] err_timeout_cnt_o;

    uart_rx_frame_parser dut (
        .sys_clk_i            (sys_clk_i),
        .rst_n_i              (rst_n_i),
        .fifo_rx_rd_en_o      (fifo_rx_rd_en_o),
        .fifo_rx_dout_valid_i (fifo_rx_dout_valid_i),
        .fifo_rx_dout_i       (fifo_rx_dout_i),
        .fifo_rx_empty_i      (fifo_rx_empty_i),
        .payload_valid_o      (payload_valid_o),
        .payload_data_o       (payload_data_o),
        .payload_last_o       (payload_last_o),
        .payload_ready_i      (payload_ready_i),
        .frame_ok_o           (frame_ok_o),
        .frame_len_o          (frame_len_o),
        .err_chk_cnt_o        (err_chk_cnt_o),
        .err_len_cnt_o        (err_len_cnt_o),
        .err_timeout_cnt_o    (err_timeout_cnt_o)
    );

    always #5 sys_clk_i = ~sys_clk_i;

    int         checks = 0;
    int         errors = 0;
    bq_t        fifo_q;
    bq_t        sb;
    logic       rd_prev;
    int         ready_mode;
    int         ready_ph;
    logic [3:0] rdy_pat;
    logic [7:0] exp_data [$];
    logic       exp_last [$];
    logic [7:0] exp_len_q [$];
    logic [7:0] rcv_data [$];
    logic       rcv_last [$];
    int         exp_chk, exp_lenerr, exp_to;
    logic [7:0] last_len_exp;
    logic       hold_prev;
    logic [7:0] prev_data;
    logic       prev_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sat(input int v);
        return (v > 255) ? 32'd255 : 32'(v);
    endfunction

    // Reference: scan for an adjacent HEAD0/HEAD1 pair, then judge LEN and checksum
    // arithmetically; resume scanning just past whatever was consumed.
    task automatic model();
        int p;
        int n;
        int len;
        logic [7:0] sum;
        p = 0;
        n = sb.size();
        while (p + 1 < n) begin
            if (sb[p] == 8'h55 && sb[p+1] == 8'hAA) begin
                if (p + 2 >= n) break;
                len = int'(sb[p+2]);
                if (len == 0 || len > MAX_LEN) begin
                    exp_lenerr++;
                    p += 3;
                    continue;
                end
                if (p + 3 + len >= n) break;
                sum = 8'(len);
                for (int k = 0; k < len; k++) sum = sum + sb[p+3+k];
                if (sb[p+3+len] == sum) begin
                    for (int k = 0; k < len; k++) begin
                        exp_data.push_back(sb[p+3+k]);
                        exp_last.push_back(k == len - 1);
                    end
                    exp_len_q.push_back(8'(len));
                end else begin
                    exp_chk++;
                end
                p += 4 + len;
            end else begin
                p++;
            end
        end
    endtask

    task automatic send_sb(input bit modeled);
        foreach (sb[i]) fifo_q.push_back(sb[i]);
        if (modeled) model();
        sb = {};
    endtask

    task automatic put_good(input int len, input bit corrupt);
        logic [7:0] sum;
        logic [7:0] b;
        sb.push_back(8'h55);
        sb.push_back(8'hAA);
        sb.push_back(8'(len));
        sum = 8'(len);
        for (int k = 0; k < len; k++) begin
            b = 8'($urandom);
            sb.push_back(b);
            sum = sum + b;
        end
        if (corrupt) sum = sum + 8'($urandom_range(1, 255));
        sb.push_back(sum);
    endtask

    task automatic step();
        @(posedge sys_clk_i);
        #1;
        if (rd_prev) begin
            chk("read_nonempty", 32'(fifo_q.size() != 0), 1);
            chk("read_spacing", fifo_rx_rd_en_o, 0);
            fifo_rx_dout_valid_i = 1'b1;
            fifo_rx_dout_i = (fifo_q.size() != 0) ? fifo_q.pop_front() : 8'h00;
        end else begin
            fifo_rx_dout_valid_i = 1'b0;
        end
        fifo_rx_empty_i = (fifo_q.size() == 0);
        rd_prev = fifo_rx_rd_en_o;

        if (hold_prev) begin
            chk("hold_valid", payload_valid_o, 1);
            chk("hold_data", payload_data_o, prev_data);
            chk("hold_last", payload_last_o, prev_last);
        end
        if (frame_ok_o) begin
            chk("ok_with_valid", payload_valid_o, 1);
            chk("ok_expected", 32'(exp_len_q.size() != 0), 1);
            if (exp_len_q.size() != 0) begin
                last_len_exp = exp_len_q.pop_front();
                chk("ok_frame_len", frame_len_o, last_len_exp);
            end
            if (rcv_data.size() < exp_data.size())
                chk("ok_first_byte", payload_data_o, exp_data[rcv_data.size()]);
        end
        if (payload_valid_o) chk("no_read_in_drain", fifo_rx_rd_en_o, 0);

        case (ready_mode)
            0:       payload_ready_i = ($urandom_range(0, 3) != 0);
            1:       payload_ready_i = 1'b1;
            2:       payload_ready_i = rdy_pat[ready_ph % 4];
            default: payload_ready_i = 1'b0;
        endcase
        ready_ph++;

        if (payload_valid_o && payload_ready_i) begin
            rcv_data.push_back(payload_data_o);
            rcv_last.push_back(payload_last_o);
        end
        hold_prev = payload_valid_o && !payload_ready_i;
        prev_data = payload_data_o;
        prev_last = payload_last_o;
    endtask

    task automatic run_idle(input int budget);
        int quiet;
        int n;
        quiet = 0;
        n = 0;
        while (quiet < 4 && n < budget) begin
            step();
            n++;
            if (fifo_q.size() == 0 && !rd_prev && !fifo_rx_dout_valid_i && !payload_valid_o)
                quiet++;
            else
                quiet = 0;
        end
        chk("settled", 32'(quiet >= 4), 1);
    endtask

    task automatic compare(input string tag);
        chk({tag, "_count"}, 32'(rcv_data.size()), 32'(exp_data.size()));
        for (int i = 0; i < exp_data.size() && i < rcv_data.size(); i++) begin
            chk({tag, "_data"}, rcv_data[i], exp_data[i]);
            chk({tag, "_last"}, rcv_last[i], exp_last[i]);
        end
        chk({tag, "_frames_left"}, 32'(exp_len_q.size()), 0);
        chk({tag, "_frame_len"}, frame_len_o, last_len_exp);
        chk({tag, "_err_chk"}, err_chk_cnt_o, sat(exp_chk));
        chk({tag, "_err_len"}, err_len_cnt_o, sat(exp_lenerr));
        chk({tag, "_err_to"}, err_timeout_cnt_o, sat(exp_to));
        exp_data = {};
        exp_last = {};
        rcv_data = {};
        rcv_last = {};
    endtask

    initial begin
        rst_n_i = 1'b0;
        fifo_rx_dout_valid_i = 1'b0;
        fifo_rx_dout_i = 8'h00;
        fifo_rx_empty_i = 1'b1;
        payload_ready_i = 1'b1;
        rd_prev = 1'b0;
        ready_mode = 1;
        ready_ph = 0;
        rdy_pat = 4'b1001;
        exp_chk = 0;
        exp_lenerr = 0;
        exp_to = 0;
        last_len_exp = 8'h00;
        hold_prev = 1'b0;
        prev_data = 8'h00;
        prev_last = 1'b0;
        sb = {};

        // Reset state
        step();
        step();
        chk("rst_rd_en", fifo_rx_rd_en_o, 0);
        chk("rst_valid", payload_valid_o, 0);
        chk("rst_data", payload_data_o, 0);
        chk("rst_last", payload_last_o, 0);
        chk("rst_frame_ok", frame_ok_o, 0);
        chk("rst_frame_len", frame_len_o, 0);
        chk("rst_err_chk", err_chk_cnt_o, 0);
        chk("rst_err_len", err_len_cnt_o, 0);
        chk("rst_err_to", err_timeout_cnt_o, 0);
        rst_n_i = 1'b1;
        step();

        // Good frame
        sb = {8'h55, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
        send_sb(1);
        run_idle(200);
        compare("good");

        // Bad checksum, then a good frame
        sb = {8'h55, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h6A,
              8'h55, 8'hAA, 8'h02, 8'hC0, 8'h01, 8'hC3};
        send_sb(1);
        run_idle(300);
        compare("badchk");

        // Resync over noise and a doubled HEAD0
        sb = {8'h00, 8'h55, 8'h55, 8'hAA, 8'h01, 8'h7F, 8'h80};
        send_sb(1);
        run_idle(200);
        compare("resync");

        // Illegal lengths (0 and MAX_LEN+1), then a MAX_LEN frame
        sb = {8'h55, 8'hAA, 8'h00, 8'h55, 8'hAA, 8'h21};
        send_sb(1);
        run_idle(200);
        compare("badlen");
        ready_mode = 0;
        put_good(MAX_LEN, 0);
        send_sb(1);
        run_idle(500);
        compare("maxlen");

        // Backpressure pattern 1,0,0,1 on a 4-byte frame
        ready_mode = 2;
        ready_ph = 0;
        sb = {8'h55, 8'hAA, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0E};
        send_sb(1);
        run_idle(300);
        compare("backpressure");

        // Randomized mix of good/bad frames, illegal lengths and noise
        ready_mode = 0;
        for (int f = 0; f < 40; f++) begin
            int kind;
            int ng;
            logic [7:0] b;
            kind = $urandom_range(0, 9);
            if (kind <= 6) begin
                put_good($urandom_range(1, MAX_LEN), kind == 6);
            end else if (kind == 7) begin
                sb.push_back(8'h55);
                sb.push_back(8'hAA);
                sb.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255)));
            end else begin
                ng = $urandom_range(1, 3);
                for (int g = 0; g < ng; g++) begin
                    b = 8'($urandom);
                    if (b == 8'h55) b = 8'h00;
                    sb.push_back(b);
                end
            end
        end
        send_sb(1);
        run_idle(20000);
        compare("random");

        // Inter-byte timeout inside a frame
        ready_mode = 1;
        sb = {8'h55, 8'hAA, 8'h02, 8'h10};
        send_sb(0);
        for (int i = 0; i < 50 && (fifo_q.size() != 0 || rd_prev || fifo_rx_dout_valid_i); i++) step();
        chk("to_fed", 32'(fifo_q.size()), 0);
        for (int i = 0; i < 49990; i++) step();
        chk("to_not_early", err_timeout_cnt_o, sat(exp_to));
        for (int i = 0; i < 20; i++) step();
        exp_to++;
        chk("to_fired", err_timeout_cnt_o, sat(exp_to));
        sb = {8'h55, 8'hAA, 8'h01, 8'h05, 8'h06};
        send_sb(1);
        run_idle(200);
        compare("after_timeout");

        // Checksum-error counter saturation
        for (int f = 0; f < 260; f++) begin
            sb.push_back(8'h55);
            sb.push_back(8'hAA);
            sb.push_back(8'h01);
            sb.push_back(8'h00);
            sb.push_back(8'h00);
        end
        send_sb(1);
        run_idle(6000);
        compare("saturate");

        // Reset while the second payload byte is presented
        ready_mode = 3;
        sb = {8'h55, 8'hAA, 8'h04, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hEE};
        send_sb(1);
        for (int i = 0; i < 100 && !payload_valid_o; i++) step();
        chk("drain_started", payload_valid_o, 1);
        ready_mode = 1;
        step();
        ready_mode = 3;
        step();
        chk("drain_byte2", payload_data_o, 8'hB2);
        rst_n_i = 1'b0;
        #1;
        chk("mrst_valid", payload_valid_o, 0);
        chk("mrst_data", payload_data_o, 0);
        chk("mrst_last", payload_last_o, 0);
        chk("mrst_frame_ok", frame_ok_o, 0);
        chk("mrst_frame_len", frame_len_o, 0);
        chk("mrst_rd_en", fifo_rx_rd_en_o, 0);
        chk("mrst_err_chk", err_chk_cnt_o, 0);
        chk("mrst_err_len", err_len_cnt_o, 0);
        chk("mrst_err_to", err_timeout_cnt_o, 0);
        fifo_q = {};
        rd_prev = 1'b0;
        hold_prev = 1'b0;
        exp_data = {};
        exp_last = {};
        exp_len_q = {};
        rcv_data = {};
        rcv_last = {};
        exp_chk = 0;
        exp_lenerr = 0;
        exp_to = 0;
        last_len_exp = 8'h00;
        step();
        step();
        rst_n_i = 1'b1;
        ready_mode = 1;
        put_good(5, 0);
        send_sb(1);
        run_idle(300);
        compare("after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
